// File: rtl/game_ctrl_gen_pkg.sv
// Shared types and helpers for the game controller.
//   state_t    : game FSM state, encoded as the gameSt output code
//   SND_*      : sound event codes driven on sndCode
//   ROW_W/COL_W: widths of the invader grid row/column indices
//   low_free() : index of the lowest clear bit in a slot busy vector
package game_pkg;

   typedef enum logic [2:0] {
      ST_START = 3'd0,
      ST_INIT  = 3'd1,
      ST_PLAY  = 3'd2,
      ST_CLEAR = 3'd3,
      ST_END   = 3'd4
   } state_t;

   localparam logic [3:0] SND_NONE = 4'd0;
   localparam logic [3:0] SND_INV  = 4'd1;
   localparam logic [3:0] SND_BOSS = 4'd2;
   localparam logic [3:0] SND_PLR  = 4'd3;
   localparam logic [3:0] SND_LVL  = 4'd4;

   localparam int ROW_W    = 4;
   localparam int COL_W    = 5;
   localparam int SLOT_W   = 3;
   localparam int SLOT_MAX = 8;

   // Scans from the top so the last write is the lowest free index.
   function automatic logic [SLOT_W-1:0] low_free(input logic [SLOT_MAX-1:0] busy);
      logic [SLOT_W-1:0] idx;
      idx = '0;
      for (int i = SLOT_MAX - 1; i >= 0; i--) begin
         if (!busy[i]) idx = SLOT_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/game_ctrl_gen_if.sv
// Bundle of every non-clock signal between the game controller and its
// neighbours (keyboard/timing sources, object drawing blocks).
//   master : the side that drives keys, ticks and pixel requests
//   slave  : the controller itself
interface game_ctrl_gen_if #(
   parameter int INV_ROWS = 8,
   parameter int INV_COLS = 16,
   parameter int BTP_MAX  = 4,
   parameter int BTI_MAX  = 4,
   parameter int SCORE_W  = 12
);
   logic                         spcKey;
   logic                         srtFrm;
   logic                         secTick;
   logic                         shotTick;
   logic [7:0]                   rndNum;
   logic                         plrReq;
   logic                         invReq;
   logic [3:0]                   invRow;
   logic [4:0]                   invCol;
   logic                         invFloor;
   logic                         bossReq;
   logic [BTP_MAX-1:0]           btpReq;
   logic [BTI_MAX-1:0]           btiReq;
   logic [BTP_MAX-1:0]           btpTop;
   logic [BTI_MAX-1:0]           btiBot;

   logic [2:0]                   gameSt;
   logic                         plrExs;
   logic [INV_ROWS*INV_COLS-1:0] invExs;
   logic                         bossExs;
   logic [BTP_MAX-1:0]           btpExs;
   logic [BTI_MAX-1:0]           btiExs;
   logic                         btiLoad;
   logic [3:0]                   btiRow;
   logic [4:0]                   btiCol;
   logic [SCORE_W-1:0]           score;
   logic [2:0]                   lives;
   logic [2:0]                   level;
   logic                         stgMsg;
   logic                         edgMsg;
   logic                         win;
   logic [3:0]                   sndCode;

   modport master (
      output spcKey, srtFrm, secTick, shotTick, rndNum, plrReq, invReq,
             invRow, invCol, invFloor, bossReq, btpReq, btiReq, btpTop, btiBot,
      input  gameSt, plrExs, invExs, bossExs, btpExs, btiExs, btiLoad,
             btiRow, btiCol, score, lives, level, stgMsg, edgMsg, win, sndCode
   );

   modport slave (
      input  spcKey, srtFrm, secTick, shotTick, rndNum, plrReq, invReq,
             invRow, invCol, invFloor, bossReq, btpReq, btiReq, btpTop, btiBot,
      output gameSt, plrExs, invExs, bossExs, btpExs, btiExs, btiLoad,
             btiRow, btiCol, score, lives, level, stgMsg, edgMsg, win, sndCode
   );
endinterface

// File: rtl/game_ctrl_gen_bolt_pool.sv
// Pool of N bolt slots.
//   i_claim   : take the lowest free slot on the next edge (ignored when full)
//   i_release : per-slot free request, applied on the next edge
//   i_clear   : free every slot
//   o_busy    : slot occupancy
//   o_idx     : slot a claim would take this cycle
//   o_ok      : at least one slot is free
module bolt_pool
   import game_pkg::*;
#(
   parameter int N = 4
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              i_claim,
   input  logic [N-1:0]      i_release,
   input  logic              i_clear,
   output logic [N-1:0]      o_busy,
   output logic [SLOT_W-1:0] o_idx,
   output logic              o_ok
);

   logic [N-1:0]        r_busy;
   logic [SLOT_MAX-1:0] w_busy_pad;

   // Slots above N read as busy so the search never lands on them.
   always_comb begin
      w_busy_pad         = '1;
      w_busy_pad[N-1:0]  = r_busy;
   end

   assign o_idx  = low_free(w_busy_pad);
   assign o_ok   = ~&r_busy;
   assign o_busy = r_busy;

   // A slot freed this cycle is not offered to a claim until the next one.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_busy <= '0;
      end else if (i_clear) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~i_release) |
                   ((i_claim && o_ok) ? (N'(1) << o_idx) : '0);
      end
   end

endmodule

// File: rtl/game_ctrl_gen.sv
// Space Invaders game controller: game FSM, invader alive-grid, bolt slot
// pools, per-frame hit accounting, saturating score, lives and level.
// Ports:
//   clk, resetN : clock, asynchronous active-low reset
//   bus         : game_ctrl_gen_if.slave (keys, ticks, pixel requests in;
//                 state, object enables, bolt load, score/lives/level,
//                 message and sound codes out)
//
// state | meaning
// ------+--------------------------------------------------------------
// START | start message shown, waiting for space
// INIT  | grid refilled, bolts cleared, waiting INIT_SECS seconds
// PLAY  | game running, hits latched and committed on each frame start
// CLEAR | level cleared, bolts cleared, waiting one second
// END   | end message shown, score held, waiting for space
module game_ctrl_gen
   import game_pkg::*;
#(
   parameter int INV_ROWS   = 8,
   parameter int INV_COLS   = 16,
   parameter int BTP_MAX    = 4,
   parameter int BTI_MAX    = 4,
   parameter int PLR_LIVES  = 3,
   parameter int BOSS_LIVES = 20,
   parameter int SCORE_STEP = 5,
   parameter int SCORE_W    = 12,
   parameter int LVL_MAX    = 7,
   parameter int INIT_SECS  = 1
) (
   input  logic            clk,
   input  logic            resetN,
   game_ctrl_gen_if.slave  bus
);

   localparam int GRID  = INV_ROWS * INV_COLS;
   localparam int IDX_W = (GRID > 1) ? $clog2(GRID) : 1;
   localparam int CNT_W = $clog2(GRID + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             r_state, w_state_nx;
   logic               r_spc_d;
   logic [SCORE_W-1:0] r_score, w_score_nx;
   logic [2:0]         r_lives, w_lives_nx;
   logic [2:0]         r_level, w_level_nx;
   logic [5:0]         r_boss_lives, w_boss_nx;
   logic [GRID-1:0]    r_grid, w_grid_nx;
   logic               r_win, w_win_nx;
   logic [3:0]         r_snd, w_snd_nx;
   logic [7:0]         r_timer, w_timer_nx;

   logic               r_pend_inv, r_pend_boss, r_pend_plr;
   logic [IDX_W-1:0]   r_pend_idx;

   logic               r_bti_load;
   logic [ROW_W-1:0]   r_bti_row;
   logic [COL_W-1:0]   r_bti_col;

   logic               w_play, w_spc_rise, w_hit_en, w_inv_valid, w_plr_hit;
   logic [BTP_MAX-1:0] w_inv_hits, w_boss_hits;
   logic [BTI_MAX-1:0] w_plr_bolt_hits;
   logic [IDX_W-1:0]   w_inv_idx, w_shot_idx;
   logic [ROW_W-1:0]   w_shot_row;
   logic [COL_W-1:0]   w_shot_col;
   logic               w_fire, w_bti_ok;
   logic [SLOT_W-1:0]  w_btp_idx, w_bti_idx;
   logic [CNT_W-1:0]   w_alive;
   logic [31:0]        w_score_sum;

   assign w_play     = (r_state == ST_PLAY);
   assign w_spc_rise = bus.spcKey & ~r_spc_d;

   // Hits arriving in the commit cycle are not latched, so nothing is lost
   // between commit and the next frame's accounting.
   assign w_hit_en    = w_play & ~bus.srtFrm;
   assign w_inv_valid = bus.invReq && (int'(bus.invRow) < INV_ROWS) &&
                        (int'(bus.invCol) < INV_COLS);
   assign w_inv_idx   = IDX_W'(int'(bus.invRow) * INV_COLS + int'(bus.invCol));

   // Only the first invader kill of a frame frees its bolt.
   assign w_inv_hits      = bus.btpReq & {BTP_MAX{w_hit_en & w_inv_valid & ~r_pend_inv}};
   assign w_boss_hits     = bus.btpReq & {BTP_MAX{w_hit_en & bus.bossReq}};
   assign w_plr_bolt_hits = bus.btiReq & {BTI_MAX{w_hit_en & bus.plrReq}};
   assign w_plr_hit       = w_hit_en & bus.plrReq & ((|bus.btiReq) | bus.bossReq);

   assign w_shot_row = ROW_W'(int'(bus.rndNum[7:4]) % INV_ROWS);
   assign w_shot_col = COL_W'(int'(bus.rndNum[3:0]) % INV_COLS);
   assign w_shot_idx = IDX_W'(int'(w_shot_row) * INV_COLS + int'(w_shot_col));
   assign w_fire     = w_play & bus.shotTick & r_grid[w_shot_idx] & w_bti_ok;

   always_comb begin
      w_alive = '0;
      for (int i = 0; i < GRID; i++) w_alive = w_alive + CNT_W'(r_grid[i]);
   end

   bolt_pool #(.N(BTP_MAX)) u_btp_pool (
      .clk       (clk),
      .resetN    (resetN),
      .i_claim   (w_play & w_spc_rise),
      .i_release (bus.btpTop | w_inv_hits | w_boss_hits),
      .i_clear   (~w_play),
      .o_busy    (bus.btpExs),
      .o_idx     (w_btp_idx),
      .o_ok      ()
   );

   bolt_pool #(.N(BTI_MAX)) u_bti_pool (
      .clk       (clk),
      .resetN    (resetN),
      .i_claim   (w_fire),
      .i_release (bus.btiBot | w_plr_bolt_hits),
      .i_clear   (~w_play),
      .o_busy    (bus.btiExs),
      .o_idx     (w_bti_idx),
      .o_ok      (w_bti_ok)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_pend_inv  <= 1'b0;
         r_pend_boss <= 1'b0;
         r_pend_plr  <= 1'b0;
         r_pend_idx  <= '0;
         r_bti_load  <= 1'b0;
         r_bti_row   <= '0;
         r_bti_col   <= '0;
         r_spc_d     <= 1'b0;
      end else begin
         r_spc_d    <= bus.spcKey;
         r_bti_load <= w_fire;
         if (w_fire) begin
            r_bti_row <= w_shot_row;
            r_bti_col <= w_shot_col;
         end
         if (bus.srtFrm) begin
            r_pend_inv  <= 1'b0;
            r_pend_boss <= 1'b0;
            r_pend_plr  <= 1'b0;
         end else begin
            if (|w_inv_hits) begin
               r_pend_inv <= 1'b1;
               r_pend_idx <= w_inv_idx;
            end
            if (|w_boss_hits) r_pend_boss <= 1'b1;
            if (w_plr_hit)    r_pend_plr  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= ST_START;
         r_score      <= '0;
         r_lives      <= 3'(PLR_LIVES);
         r_level      <= 3'd1;
         r_boss_lives <= '0;
         r_grid       <= '0;
         r_win        <= 1'b0;
         r_snd        <= SND_NONE;
         r_timer      <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_score      <= w_score_nx;
         r_lives      <= w_lives_nx;
         r_level      <= w_level_nx;
         r_boss_lives <= w_boss_nx;
         r_grid       <= w_grid_nx;
         r_win        <= w_win_nx;
         r_snd        <= w_snd_nx;
         r_timer      <= w_timer_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_score_nx  = r_score;
      w_lives_nx  = r_lives;
      w_level_nx  = r_level;
      w_boss_nx   = r_boss_lives;
      w_grid_nx   = r_grid;
      w_win_nx    = r_win;
      w_snd_nx    = r_snd;
      w_timer_nx  = r_timer;
      w_score_sum = 32'(r_score) + (r_pend_inv  ? 32'(SCORE_STEP)     : 32'd0)
                                 + (r_pend_boss ? 32'(4 * SCORE_STEP) : 32'd0);

      // A sound code lives exactly one frame.
      if (bus.srtFrm) w_snd_nx = SND_NONE;

      case (r_state)
         ST_START: begin
            if (w_spc_rise) begin
               w_state_nx = ST_INIT;
               w_score_nx = '0;
               w_lives_nx = 3'(PLR_LIVES);
               w_level_nx = 3'd1;
               w_boss_nx  = 6'(BOSS_LIVES);
               w_win_nx   = 1'b0;
               w_timer_nx = 8'(INIT_SECS);
            end
         end
         ST_INIT: begin
            w_grid_nx = '1;
            if (bus.secTick) begin
               if (r_timer <= 8'd1) w_state_nx = ST_PLAY;
               else                 w_timer_nx = r_timer - 8'd1;
            end
         end
         ST_PLAY: begin
            if (bus.srtFrm) begin
               if (r_pend_inv) w_grid_nx[r_pend_idx] = 1'b0;
               w_score_nx = (w_score_sum > 32'(SCORE_MAX)) ? SCORE_MAX
                                                          : SCORE_W'(w_score_sum);
               if (r_pend_boss && r_boss_lives != 6'd0) w_boss_nx  = r_boss_lives - 6'd1;
               if (r_pend_plr  && r_lives != 3'd0)      w_lives_nx = r_lives - 3'd1;
               if (r_pend_plr)       w_snd_nx = SND_PLR;
               else if (r_pend_boss) w_snd_nx = SND_BOSS;
               else if (r_pend_inv)  w_snd_nx = SND_INV;

               // Exits look at the post-commit values, so a last-life hit
               // outranks a grid clear in the same frame.
               if (w_lives_nx == 3'd0 || bus.invFloor) begin
                  w_state_nx = ST_END;
                  w_win_nx   = 1'b0;
               end else if (w_grid_nx == '0) begin
                  w_snd_nx = SND_LVL;
                  if (int'(r_level) == LVL_MAX) begin
                     w_state_nx = ST_END;
                     w_win_nx   = 1'b1;
                  end else begin
                     w_state_nx = ST_CLEAR;
                     w_level_nx = r_level + 3'd1;
                  end
               end
            end
         end
         ST_CLEAR: begin
            if (bus.secTick) begin
               w_state_nx = ST_INIT;
               w_timer_nx = 8'(INIT_SECS);
            end
         end
         ST_END: begin
            if (w_spc_rise) w_state_nx = ST_START;
         end
         default: w_state_nx = ST_START;
      endcase
   end

   assign bus.gameSt  = r_state;
   assign bus.plrExs  = w_play;
   assign bus.invExs  = r_grid;
   assign bus.bossExs = w_play && (int'(w_alive) * 4 < GRID * 3) && (r_boss_lives != 6'd0);
   assign bus.btiLoad = r_bti_load;
   assign bus.btiRow  = r_bti_row;
   assign bus.btiCol  = r_bti_col;
   assign bus.score   = r_score;
   assign bus.lives   = r_lives;
   assign bus.level   = r_level;
   assign bus.stgMsg  = (r_state == ST_START);
   assign bus.edgMsg  = (r_state == ST_END);
   assign bus.win     = r_win;
   assign bus.sndCode = r_snd;

endmodule

// File: tb/tb_game_ctrl_gen.sv
module tb_game_ctrl_gen;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   game_ctrl_gen_if #(.INV_ROWS(8), .INV_COLS(16), .BTP_MAX(4), .BTI_MAX(4), .SCORE_W(12)) b0 ();
   game_ctrl_gen_if #(.INV_ROWS(2), .INV_COLS(2),  .BTP_MAX(4), .BTI_MAX(4), .SCORE_W(5))  b1 ();

   game_ctrl_gen u0 (.clk(clk), .resetN(resetN), .bus(b0));

   game_ctrl_gen #(
      .INV_ROWS(2), .INV_COLS(2), .BTP_MAX(4), .BTI_MAX(4), .PLR_LIVES(3),
      .BOSS_LIVES(3), .SCORE_STEP(5), .SCORE_W(5), .LVL_MAX(2), .INIT_SECS(1)
   ) u1 (.clk(clk), .resetN(resetN), .bus(b1));

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] sb_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
      end else begin
         e = sb_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic idle0();
      b0.spcKey = 0; b0.srtFrm = 0; b0.secTick = 0; b0.shotTick = 0; b0.rndNum = 0;
      b0.plrReq = 0; b0.invReq = 0; b0.invRow = 0; b0.invCol = 0; b0.invFloor = 0;
      b0.bossReq = 0; b0.btpReq = 0; b0.btiReq = 0; b0.btpTop = 0; b0.btiBot = 0;
   endtask

   task automatic idle1();
      b1.spcKey = 0; b1.srtFrm = 0; b1.secTick = 0; b1.shotTick = 0; b1.rndNum = 0;
      b1.plrReq = 0; b1.invReq = 0; b1.invRow = 0; b1.invCol = 0; b1.invFloor = 0;
      b1.bossReq = 0; b1.btpReq = 0; b1.btiReq = 0; b1.btpTop = 0; b1.btiBot = 0;
   endtask

   task automatic press0(); b0.spcKey = 1; tick(); b0.spcKey = 0; tick(); endtask
   task automatic sec0();   b0.secTick = 1; tick(); b0.secTick = 0; endtask
   task automatic frame0(); b0.srtFrm = 1; tick(); b0.srtFrm = 0; endtask
   task automatic kill0(input int r, input int c);
      b0.invReq = 1; b0.invRow = 4'(r); b0.invCol = 5'(c); b0.btpReq = 4'b0001;
      tick();
      b0.invReq = 0; b0.btpReq = 0;
   endtask

   task automatic press1(); b1.spcKey = 1; tick(); b1.spcKey = 0; tick(); endtask
   task automatic sec1();   b1.secTick = 1; tick(); b1.secTick = 0; endtask
   task automatic frame1(); b1.srtFrm = 1; tick(); b1.srtFrm = 0; endtask
   task automatic kill1(input int r, input int c);
      b1.invReq = 1; b1.invRow = 4'(r); b1.invCol = 5'(c); b1.btpReq = 4'b0001;
      tick();
      b1.invReq = 0; b1.btpReq = 0;
   endtask

   initial begin
      int k;
      idle0();
      idle1();
      resetN = 0;
      repeat (3) tick();

      chk("rst_state", 32'(b0.gameSt), 0);
      chk("rst_lives", 32'(b0.lives), 3);
      chk("rst_level", 32'(b0.level), 1);
      chk("rst_score", 32'(b0.score), 0);
      chk("rst_grid",  32'($countones(b0.invExs)), 0);
      chk("rst_btp",   32'(b0.btpExs), 0);
      chk("rst_edg",   32'(b0.edgMsg), 0);
      resetN = 1;
      tick();

      // start a game
      press0();
      chk("init_state", 32'(b0.gameSt), 1);
      chk("init_grid",  32'(&b0.invExs), 1);
      sec0();
      chk("play_state", 32'(b0.gameSt), 2);
      chk("play_plr",   32'(b0.plrExs), 1);
      chk("play_lives", 32'(b0.lives), 3);
      chk("play_score", 32'(b0.score), 0);
      chk("play_level", 32'(b0.level), 1);

      // player fire: 5 edges into 4 slots
      repeat (5) press0();
      chk("btp_full", 32'(b0.btpExs), 32'hF);
      b0.btpTop = 4'b0100; tick(); b0.btpTop = 0;
      chk("btp_top2", 32'(b0.btpExs), 32'hB);

      // invader kill at (3,7), second kill in the same frame ignored
      kill0(3, 7);
      chk("kill_free",   32'(b0.btpExs), 32'hA);
      chk("kill_defer",  32'(b0.invExs[55]), 1);
      b0.invReq = 1; b0.invRow = 0; b0.invCol = 0; b0.btpReq = 4'b0010;
      tick();
      b0.invReq = 0; b0.btpReq = 0;
      chk("kill2_nofree", 32'(b0.btpExs), 32'hA);
      sb_q.push_back(5);
      sb_q.push_back(1);
      frame0();
      sb_pop("commit_score", 32'(b0.score));
      sb_pop("commit_snd",   32'(b0.sndCode));
      chk("commit_bit55", 32'(b0.invExs[55]), 0);
      chk("kill2_bit0",   32'(b0.invExs[0]), 1);

      // out-of-grid row is ignored
      b0.invReq = 1; b0.invRow = 4'd9; b0.invCol = 0; b0.btpReq = 4'b0010;
      tick();
      b0.invReq = 0; b0.btpReq = 0;
      chk("badrow_nofree", 32'(b0.btpExs), 32'hA);
      frame0();
      chk("badrow_alive", 32'($countones(b0.invExs)), 127);
      chk("snd_oneframe", 32'(b0.sndCode), 0);

      // invader fire at a dead cell, then a live one
      b0.rndNum = 8'h37; b0.shotTick = 1; tick(); b0.shotTick = 0;
      chk("dead_noload", 32'(b0.btiLoad), 0);
      tick();
      chk("dead_noload2", 32'(b0.btiLoad), 0);
      chk("dead_noslot",  32'(b0.btiExs), 0);
      b0.rndNum = 8'hB2;
      sb_q.push_back(32'({4'd3, 5'd2}));
      b0.shotTick = 1; tick(); b0.shotTick = 0;
      k = 0;
      while (!b0.btiLoad && k < 4) begin tick(); k++; end
      if (b0.btiLoad) sb_pop("bti_loc", 32'({b0.btiRow, b0.btiCol}));
      else begin
         void'(sb_q.pop_front());
         chk("bti_load_seen", 32'(b0.btiLoad), 1);
      end
      chk("bti_slot", 32'(b0.btiExs), 1);

      // three player hits
      b0.plrReq = 1; b0.btiReq = 4'b0001; tick(); b0.plrReq = 0; b0.btiReq = 0;
      chk("plr_free", 32'(b0.btiExs), 0);
      sb_q.push_back(2);
      sb_q.push_back(3);
      frame0();
      sb_pop("hit1_lives", 32'(b0.lives));
      sb_pop("hit1_snd",   32'(b0.sndCode));
      frame0();
      chk("hit1_snd_off", 32'(b0.sndCode), 0);
      b0.plrReq = 1; b0.bossReq = 1; tick(); b0.plrReq = 0; b0.bossReq = 0;
      sb_q.push_back(1);
      frame0();
      sb_pop("hit2_lives", 32'(b0.lives));
      b0.plrReq = 1; b0.btiReq = 4'b0100; tick(); b0.plrReq = 0; b0.btiReq = 0;
      sb_q.push_back(0);
      frame0();
      sb_pop("hit3_lives", 32'(b0.lives));
      chk("end_state", 32'(b0.gameSt), 4);
      chk("end_msg",   32'(b0.edgMsg), 1);
      chk("end_win",   32'(b0.win), 0);
      chk("end_score", 32'(b0.score), 5);
      press0();
      chk("restart", 32'(b0.gameSt), 0);

      // new game, clear the whole grid
      press0();
      sec0();
      chk("g2_play",  32'(b0.gameSt), 2);
      chk("g2_score", 32'(b0.score), 0);
      chk("g2_lives", 32'(b0.lives), 3);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 16; c++) begin
            kill0(r, c);
            frame0();
            if (r * 16 + c + 1 == 32) chk("boss_off_96", 32'(b0.bossExs), 0);
            if (r * 16 + c + 1 == 33) chk("boss_on_95",  32'(b0.bossExs), 1);
         end
      end
      chk("clr_state", 32'(b0.gameSt), 3);
      chk("clr_level", 32'(b0.level), 2);
      chk("clr_score", 32'(b0.score), 640);
      chk("clr_snd",   32'(b0.sndCode), 4);
      sec0();
      tick();
      chk("l2_init", 32'(b0.gameSt), 1);
      chk("l2_grid", 32'(&b0.invExs), 1);
      sec0();
      chk("l2_play", 32'(b0.gameSt), 2);

      // small instance: boss, saturation, last-level win
      press1();
      sec1();
      chk("s_play", 32'(b1.gameSt), 2);
      chk("s_grid", 32'(b1.invExs), 32'hF);
      kill1(0, 0); frame1();
      chk("s_score5", 32'(b1.score), 5);
      chk("s_boss_off", 32'(b1.bossExs), 0);
      kill1(0, 1); frame1();
      chk("s_boss_on", 32'(b1.bossExs), 1);
      b1.bossReq = 1; b1.btpReq = 4'b0001; tick(); b1.bossReq = 0; b1.btpReq = 0;
      sb_q.push_back(30);
      sb_q.push_back(2);
      frame1();
      sb_pop("s_boss_score", 32'(b1.score));
      sb_pop("s_boss_snd",   32'(b1.sndCode));
      sb_q.push_back(31);
      kill1(1, 0); frame1();
      sb_pop("s_saturate", 32'(b1.score));
      kill1(1, 1); frame1();
      chk("s_clear", 32'(b1.gameSt), 3);
      chk("s_level", 32'(b1.level), 2);
      sec1();
      tick();
      sec1();
      chk("s_l2_grid", 32'(b1.invExs), 32'hF);
      kill1(0, 0); frame1();
      kill1(0, 1); frame1();
      kill1(1, 0); frame1();
      b1.plrReq = 1; b1.btiReq = 4'b0001;
      kill1(1, 1);
      b1.plrReq = 0; b1.btiReq = 0;
      frame1();
      chk("s_win_state", 32'(b1.gameSt), 4);
      chk("s_win",       32'(b1.win), 1);
      chk("s_win_lives", 32'(b1.lives), 2);
      chk("s_win_score", 32'(b1.score), 31);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/game_ctrl_gen.md
Name: game_ctrl_gen

Overview:
- Parametrised next-generation game controller for the Space Invaders VGA design.
- Owns the game FSM, the invader alive-grid, player and invader bolt slot allocation, per-frame hit accounting, score, lives and level.
- Sits between the keyboard/timing blocks and the object drawing blocks.
- Adds to the current controller: configurable grid and bolt counts, separate player/invader bolt pools, multi-level progression with restart, frame-synchronised event commit, and a saturating score.

Parameters:
- INV_ROWS, 8, invader grid rows (1..16).
- INV_COLS, 16, invader grid columns (1..32).
- BTP_MAX, 4, player bolt slots (1..8).
- BTI_MAX, 4, invader bolt slots (1..8).
- PLR_LIVES, 3, lives at game start (1..7).
- BOSS_LIVES, 20, hits required to kill the boss (1..63).
- SCORE_STEP, 5, points per invader hit; the boss awards 4*SCORE_STEP.
- SCORE_W, 12, score width.
- LVL_MAX, 7, last level; clearing it ends the game as a win.
- INIT_SECS, 1, seconds spent in INIT.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- spcKey  in  1  space key level
- srtFrm  in  1  one-cycle pulse at frame start
- secTick  in  1  one-cycle pulse per second
- shotTick  in  1  invader fire opportunity pulse
- rndNum  in  8  pseudo-random value
- plrReq  in  1  player pixel drawing request
- invReq  in  1  invader pixel drawing request
- invRow  in  4  grid row of the current invader pixel
- invCol  in  5  grid column of the current invader pixel
- invFloor  in  1  invader grid reached the floor line
- bossReq  in  1  boss pixel drawing request
- btpReq  in  BTP_MAX  player bolt pixel requests
- btiReq  in  BTI_MAX  invader bolt pixel requests
- btpTop  in  BTP_MAX  player bolt left the top border
- btiBot  in  BTI_MAX  invader bolt left the bottom border
- gameSt  out  3  FSM state code
- plrExs  out  1  player enabled
- invExs  out  INV_ROWS*INV_COLS  alive grid, row-major
- bossExs  out  1  boss enabled
- btpExs  out  BTP_MAX  player bolt slot busy
- btiExs  out  BTI_MAX  invader bolt slot busy
- btiLoad  out  1  one-cycle pulse: load the shooter location
- btiRow  out  4  shooter row
- btiCol  out  5  shooter column
- score  out  SCORE_W  score
- lives  out  3  lives remaining
- level  out  3  current level
- stgMsg  out  1  show start message
- edgMsg  out  1  show end message
- win  out  1  game won
- sndCode  out  4  sound event code; non-zero for one frame

Behaviour:
- Reset: resetN, asynchronous, active-low; clock clk. Every register resets to 0 (state START, all outputs 0), except lives=PLR_LIVES and level=1.
- FSM states: START, INIT, PLAY, CLEAR, END. gameSt codes are 0..4 in that order.
- START: stgMsg=1. On a rising edge of spcKey: go to INIT, set score=0, lives=PLR_LIVES, level=1, boss lives=BOSS_LIVES.
- INIT: invExs set to all ones; every bolt slot cleared. After INIT_SECS secTick pulses, go to PLAY.
- PLAY:
  - plrExs=1.
  - bossExs=1 once the alive count is below 3/4 of the grid and boss lives are greater than 0.
- Player fire: on a rising edge of spcKey, claim the lowest-index free btpExs slot in the next cycle. If no slot is free, the shot is dropped.
- Invader fire: on shotTick, take row=rndNum[7:4] mod INV_ROWS and column=rndNum[3:0] mod INV_COLS. If that cell is alive and a btiExs slot is free:
  - claim the lowest free slot;
  - pulse btiLoad with btiRow/btiCol, one cycle after shotTick.
- Slot release: btpTop[i] or btiBot[i] clears slot i on the next cycle.
- Hits: a hit is any coincidence in the same cycle.
  - invReq & btpReq[i]: latch pending kill of (invRow, invCol), free slot i.
  - bossReq & btpReq[i]: latch pending boss hit, free slot i.
  - plrReq & (btiReq[i] | bossReq): latch pending player hit; free slot i if a bolt was involved.
  - Slot release is immediate. Grid, score, lives and boss changes commit on the next srtFrm.
  - At most one of each event type commits per frame. The first invader kill latched in a frame wins; later ones in the same frame are ignored and do not free their bolt.
- Commit on srtFrm:
  - Clear the killed grid bit; score += SCORE_STEP.
  - Boss hit: boss lives -1; score += 4*SCORE_STEP.
  - Player hit: lives -1.
  - Score saturates at 2^SCORE_W-1.
  - sndCode for one frame: 1 invader, 2 boss, 3 player hit, 4 level clear.
- PLAY exits, checked after commit:
  - lives==0 or invFloor → END, win=0.
  - Grid all zero → CLEAR.
- CLEAR: bolts cleared, level +1, after one secTick go to INIT. If level==LVL_MAX at entry, go to END with win=1 instead.
- END: edgMsg=1, score held. A rising edge of spcKey returns to START.
- Simultaneous events: a player hit and the last invader kill in the same frame resolve to CLEAR if lives remain after the decrement, otherwise END.
- Invalid indices: invRow/invCol outside the grid are ignored.

Decomposition:
- Package game_pkg holds: the state enum, the sound code constants, the grid index widths, and a function for the lowest-free-slot index.
- Sub-module bolt_pool:
  - parametrised by N;
  - inputs: claim, release vector, clear;
  - outputs: busy vector, claimed index, ok.
  - Instantiated twice, once for player bolts and once for invader bolts.

Test Plan:
- Reset, then space edge → START to INIT; after 1 secTick, PLAY. Required: lives=3, score=0, level=1, invExs all ones.
- 5 space edges within one frame, BTP_MAX=4 → btpExs=4'hF, 5th shot dropped. Pulse btpTop[2] → btpExs=4'hB.
- invReq with row 3, col 7 plus btpReq[0] → slot 0 freed next cycle. At srtFrm: grid bit 55 cleared, score=5, sndCode=1. Second kill in the same frame → no change.
- Three player hits in separate frames → lives 3,2,1,0; then END with edgMsg=1 and win=0. Space edge → START.
- Kill all 128 invaders → CLEAR, level=2, then INIT with full grid. With level=LVL_MAX → END with win=1.
- Score preloaded to 4094, SCORE_W=12, boss hit → score=4095 (saturated). shotTick at a dead cell → no btiLoad.
